// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access master: default widths and FSM states.
package dm_pkg;

  localparam int unsigned DM_DATA_W = 32;
  localparam int unsigned DM_ADDR_W = 32;
  localparam int unsigned DM_DEPTH  = 32;
  localparam int unsigned DM_LEN_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAPT,
    RD_RESP
  } dmState_t;

endpackage

// File: rtl/dm_access_master.sv
// Burst initiator for the single-port data memory: converts load/store bursts into
// registered we_DM/addDM/dataDM drive and returns captured outDM read data.
module dm_access_master
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DEPTH  = DM_DEPTH,
  parameter int unsigned LEN_W  = DM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              we_DM,
  output logic [ADDR_W-1:0] addDM,
  output logic [DATA_W-1:0] dataDM,
  input  logic [DATA_W-1:0] outDM
);

  dmState_t          state;
  logic [ADDR_W-1:0] curAddr;
  logic [LEN_W-1:0]  beatsLeft;
  logic [ADDR_W-1:0] nextAddr;

  // DEPTH is a power of two, so modulo reduces to a mask.
  function automatic logic [ADDR_W-1:0] wrapAddr(input logic [ADDR_W-1:0] a);
    return a & ADDR_W'(DEPTH - 1);
  endfunction

  assign nextAddr  = wrapAddr(curAddr + 1'b1);
  assign req_ready = (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      curAddr   <= '0;
      beatsLeft <= '0;
      we_DM     <= 1'b0;
      addDM     <= '0;
      dataDM    <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_DM <= 1'b0;
          if (req_valid) begin
            curAddr   <= wrapAddr(req_addr);
            beatsLeft <= req_len;
            if (req_we) begin
              state <= WRITE;
            end else begin
              addDM <= wrapAddr(req_addr);
              state <= RD_ISSUE;
            end
          end
        end

        WRITE: begin
          if (wr_valid) begin
            we_DM   <= 1'b1;
            addDM   <= curAddr;
            dataDM  <= wr_data;
            curAddr <= nextAddr;
            if (beatsLeft == '0) state <= IDLE;
            else beatsLeft <= beatsLeft - 1'b1;
          end else begin
            we_DM <= 1'b0;
          end
        end

        RD_ISSUE: begin
          we_DM <= 1'b0;
          state <= RD_CAPT;
        end

        RD_CAPT: begin
          we_DM    <= 1'b0;
          rd_data  <= outDM;
          rd_valid <= 1'b1;
          rd_last  <= (beatsLeft == '0);
          state    <= RD_RESP;
        end

        RD_RESP: begin
          we_DM <= 1'b0;
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_last) begin
              state <= IDLE;
            end else begin
              beatsLeft <= beatsLeft - 1'b1;
              curAddr   <= nextAddr;
              addDM     <= nextAddr;
              state     <= RD_ISSUE;
            end
          end
        end

        default: begin
          we_DM <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
